// File: rtl/secded_codec.sv
// secded_codec: two-stage pipelined Hamming SECDED encoder/decoder with saturating decode statistics
// Ports: clk/reset (async, active-high); in_valid/in_ready/in_enc/in_data beat input (in_enc=1 encodes);
// out_valid/out_ready/out_data/out_stat result (stat 00 clean, 01 corrected, 10 double);
// cnt_clr clears cnt_clean/cnt_single/cnt_double, which count decode outcomes on output handshakes.
module secded_codec #(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 8,
    localparam int CODE_W = 1 << PAR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_enc,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic [1:0]        out_stat,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_clean,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);
    // Data bits occupy every non-power-of-two position >= 3, ascending.
    function automatic logic [CODE_W-1:0] scatter(input logic [DATA_W-1:0] d);
        int j;
        scatter = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++)
            if ((i & (i - 1)) != 0) begin
                scatter[i] = d[j];
                j++;
            end
    endfunction

    function automatic logic [DATA_W-1:0] gather(input logic [CODE_W-1:0] cw);
        int j;
        gather = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++)
            if ((i & (i - 1)) != 0) begin
                gather[j] = cw[i];
                j++;
            end
    endfunction

    function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] cw);
        syndrome = '0;
        for (int i = 1; i < CODE_W; i++)
            if (cw[i]) syndrome ^= PAR_W'(i);
    endfunction

    logic              s1_v, s1_enc, s1_p, s2_v, s2_enc;
    logic [PAR_W-1:0]  s1_s;
    logic [CODE_W-1:0] s1_cw, s2_data, in_cw, enc_cw, fix_cw, dec_out;
    logic [1:0]        s2_stat, dec_stat;
    logic              s1_adv, s2_adv, hs_dec;

    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;
    assign out_data  = s2_data;
    assign out_stat  = s2_stat;
    assign hs_dec    = s2_v && out_ready && !s2_enc;

    // For encode, S1 holds the data-only codeword, so its syndrome is exactly the
    // parity-bit vector and its XOR is the parity of the data bits.
    assign in_cw = in_enc ? scatter(in_data[DATA_W-1:0]) : in_data;

    always_comb begin
        enc_cw = s1_cw;
        for (int k = 0; k < PAR_W; k++) enc_cw[1 << k] = s1_s[k];
        enc_cw[0] = s1_p ^ (^s1_s);
    end

    // P=1 flips bit s (s=0 targets the overall parity bit); P=0 leaves the word raw.
    assign fix_cw   = s1_cw ^ (s1_p ? CODE_W'(1) << s1_s : '0);
    assign dec_stat = s1_p ? 2'b01 : (s1_s != '0 ? 2'b10 : 2'b00);
    assign dec_out  = CODE_W'(gather(fix_cw)) | {dec_stat, {(CODE_W-2){1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v       <= 1'b0;
            s1_enc     <= 1'b0;
            s1_p       <= 1'b0;
            s1_s       <= '0;
            s1_cw      <= '0;
            s2_v       <= 1'b0;
            s2_enc     <= 1'b0;
            s2_data    <= '0;
            s2_stat    <= 2'b00;
            cnt_clean  <= '0;
            cnt_single <= '0;
            cnt_double <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_enc <= in_enc;
                    s1_cw  <= in_cw;
                    s1_s   <= syndrome(in_cw);
                    s1_p   <= ^in_cw;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_enc  <= s1_enc;
                    s2_data <= s1_enc ? enc_cw : dec_out;
                    s2_stat <= s1_enc ? 2'b00 : dec_stat;
                end
            end
            cnt_clean  <= cnt_clr ? '0 : cnt_clean  + CNT_W'(hs_dec && s2_stat == 2'b00 && cnt_clean  != '1);
            cnt_single <= cnt_clr ? '0 : cnt_single + CNT_W'(hs_dec && s2_stat == 2'b01 && cnt_single != '1);
            cnt_double <= cnt_clr ? '0 : cnt_double + CNT_W'(hs_dec && s2_stat == 2'b10 && cnt_double != '1);
        end
    end
endmodule
